ntt_index_sequencer: RTL and testbench

- Sequences the (k, i, p) loop indices that drive the 1024-point radix-2 NTT address generator with 4 butterfly units, i.e. 8 coefficient addresses per issued tuple.
- Sits directly upstream of the address generator.
- Started by the top-level NTT controller; issues 128 tuples per stage over 10 stages, with a pipeline-drain gap between stages.
- Uses a valid/ready handshake so the datapath can back-pressure.

---
 rtl/ntt_seq_pkg.sv | 17 +
 rtl/ntt_stage_limits.sv | 32 +++
 rtl/ntt_index_sequencer.sv | 177 +++++++++++++++++
 tb/tb_ntt_index_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_seq_pkg.sv
// ntt_seq_pkg: shared constants and FSM state type for the NTT index sequencer.
// Sizes match a 1024-point radix-2 NTT with 4 butterflies (128 tuples per stage).
package ntt_seq_pkg;
  localparam int LOGN = 10;
  localparam int N_STAGES = 10;
  localparam int TUPLES_PER_STAGE = 128;
  localparam int KW = 7;
  localparam int IW = 7;
  localparam int PW = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    GAP,
    DONE
  } state_t;
endpackage

// File: rtl/ntt_stage_limits.sv
// ntt_stage_limits: per-stage loop bounds (k_max, i_max) derived from stage p.
// (k_max+1)*(i_max+1) is always 128; out-of-range p saturates to the p=9 shape.
module ntt_stage_limits
  import ntt_seq_pkg::*;
(
  input  logic [PW-1:0] p_i,
  output logic [KW-1:0] k_max_o,
  output logic [IW-1:0] i_max_o
);
  localparam logic [KW-1:0] KALL = {KW{1'b1}};
  localparam logic [IW-1:0] IALL = {IW{1'b1}};

  // Early stages are flat; later stages trade outer groups for inner span
  always_comb begin
    k_max_o = KALL;
    i_max_o = '0;
    unique case (1'b1)
      (p_i < 4'd2): begin
        k_max_o = KALL;
        i_max_o = '0;
      end
      (p_i > 4'd9): begin
        k_max_o = '0;
        i_max_o = IALL;
      end
      default: begin
        k_max_o = KALL >> (p_i - 4'd2);
        i_max_o = IALL >> (4'd9 - p_i);
      end
    endcase
  end
endmodule

// File: rtl/ntt_index_sequencer.sv
// ntt_index_sequencer: issues (k,i,p) tuples for the NTT address generator.
// Optional NTT_INV_ORDER_EN adds an inv input that runs stages 9 down to 0.
module ntt_index_sequencer #(
  parameter int GAP_CYCLES = 4,
  parameter int LOGN = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       ready,
`ifdef NTT_INV_ORDER_EN
  input  logic       inv,
`endif
  output logic [6:0] k,
  output logic [6:0] i,
  output logic [3:0] p,
  output logic       valid,
  output logic       busy,
  output logic       done
);
  import ntt_seq_pkg::*;

  localparam logic [PW-1:0] P_LAST = PW'(LOGN - 1);
  localparam logic [3:0] GAP_LAST =
    (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
  localparam bit HAS_GAP = (GAP_CYCLES > 0);

  state_t state_q, state_d;
  logic [KW-1:0] k_q, k_d, k_max;
  logic [IW-1:0] i_q, i_d, i_max;
  logic [PW-1:0] p_q, p_d, p_next, p_first;
  logic [3:0] gcnt_q, gcnt_d;
  logic valid_q, valid_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic inv_q, inv_d, inv_in;
  logic consume, i_wrap, k_wrap;
  logic last_tuple, last_stage, gap_end;

`ifdef NTT_INV_ORDER_EN
  assign inv_in = inv;
`else
  assign inv_in = 1'b0;
`endif

  ntt_stage_limits u_limits (
    .p_i     (p_q),
    .k_max_o (k_max),
    .i_max_o (i_max)
  );

  assign consume = valid_q & ready;
  assign i_wrap = (i_q == i_max);
  assign k_wrap = (k_q == k_max);
  assign last_tuple = i_wrap & k_wrap;
  assign last_stage = inv_q ? (p_q == '0) : (p_q == P_LAST);
  assign p_next = inv_q ? (p_q - 4'd1) : (p_q + 4'd1);
  assign p_first = inv_in ? P_LAST : '0;
  assign gap_end = (gcnt_q == GAP_LAST);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end

  // FSM next-state: run until the last tuple of the last stage is taken
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (consume && last_tuple) begin
          if (last_stage) state_d = DONE;
          else if (HAS_GAP) state_d = GAP;
        end
      end
      GAP: if (gap_end) state_d = RUN;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered indices, flags and gap counter
  always_comb begin
    k_d = k_q;
    i_d = i_q;
    p_d = p_q;
    valid_d = valid_q;
    busy_d = busy_q;
    done_d = 1'b0;
    gcnt_d = gcnt_q;
    inv_d = inv_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          k_d = '0;
          i_d = '0;
          p_d = p_first;
          valid_d = 1'b1;
          busy_d = 1'b1;
          gcnt_d = '0;
          inv_d = inv_in;
        end
      end
      RUN: begin
        if (consume) begin
          if (!last_tuple) begin
            if (i_wrap) begin
              i_d = '0;
              k_d = k_q + 7'd1;
            end else begin
              i_d = i_q + 7'd1;
            end
          end else if (last_stage) begin
            valid_d = 1'b0;
            busy_d = 1'b0;
            done_d = 1'b1;
          end else if (HAS_GAP) begin
            valid_d = 1'b0;
            gcnt_d = '0;
          end else begin
            p_d = p_next;
            k_d = '0;
            i_d = '0;
          end
        end
      end
      GAP: begin
        gcnt_d = gcnt_q + 4'd1;
        if (gap_end) begin
          p_d = p_next;
          k_d = '0;
          i_d = '0;
          valid_d = 1'b1;
          gcnt_d = '0;
        end
      end
      DONE: begin
        done_d = 1'b0;
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  // Output and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q <= '0;
      i_q <= '0;
      p_q <= '0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      gcnt_q <= '0;
      inv_q <= 1'b0;
    end else begin
      k_q <= k_d;
      i_q <= i_d;
      p_q <= p_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
      done_q <= done_d;
      gcnt_q <= gcnt_d;
      inv_q <= inv_d;
    end
  end

  assign k = k_q;
  assign i = i_q;
  assign p = p_q;
  assign valid = valid_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_ntt_index_sequencer.sv
// tb_ntt_index_sequencer: scoreboard bench for the NTT index sequencer.
// Expected tuples are queued per run; a negedge monitor pops on every consume.
module tb_ntt_index_sequencer;
  import ntt_seq_pkg::*;

  localparam int G = 4;

  logic clk = 1'b0;
  logic rst_n, start, ready;
  logic [6:0] k, i;
  logic [3:0] p;
  logic valid, busy, done;
`ifdef NTT_INV_ORDER_EN
  logic inv;
`endif

  typedef struct packed {
    logic [6:0] k;
    logic [6:0] i;
    logic [3:0] p;
    logic last;
  } exp_t;

  exp_t q[$];
  int nvec = 0;
  int nerr = 0;
  int npop = 0;
  int cyc = 0;
  int first_cyc = -1;
  int done_cyc = 0;
  int ndone = 0;
  bit mid_stage = 0;
  bit bp_en = 0;
  bit spot_en = 0;

  int hidx[10] = '{0, 128, 256, 383, 384, 385, 386, 511, 1152, 1279};
  logic [6:0] hk[10] = '{0, 0, 0, 127, 0, 0, 1, 63, 0, 0};
  logic [6:0] hi[10] = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 127};
  logic [3:0] hp[10] = '{0, 1, 2, 2, 3, 3, 3, 3, 9, 9};

  logic [6:0] lkx[10] = '{127, 127, 127, 63, 31, 15, 7, 3, 1, 0};
  logic [6:0] lix[10] = '{0, 0, 0, 1, 3, 7, 15, 31, 63, 127};
  logic [3:0] lp;
  logic [6:0] lk, li;

  ntt_index_sequencer #(.GAP_CYCLES(G), .LOGN(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .ready (ready),
`ifdef NTT_INV_ORDER_EN
    .inv   (inv),
`endif
    .k     (k),
    .i     (i),
    .p     (p),
    .valid (valid),
    .busy  (busy),
    .done  (done)
  );

  ntt_stage_limits u_lim (
    .p_i     (lp),
    .k_max_o (lk),
    .i_max_o (li)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push_run(input bit rev);
    int pp, ni, nk;
    for (int s = 0; s < 10; s++) begin
      pp = rev ? 9 - s : s;
      ni = (pp < 2) ? 1 : (1 << (pp - 2));
      nk = 128 / ni;
      for (int kk = 0; kk < nk; kk++)
        for (int ii = 0; ii < ni; ii++)
          q.push_back(exp_t'({7'(kk), 7'(ii), 4'(pp),
                              (kk == nk - 1) && (ii == ni - 1)}));
    end
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int n0;
    int c;
    n0 = ndone;
    c = 0;
    while (ndone == n0 && c < budget) begin
      @(posedge clk);
      c++;
    end
    if (ndone == n0) begin
      nvec++;
      nerr++;
      $display("FAIL %s: no done within %0d cycles", nm, budget);
    end
  endtask

  task automatic wait_pops(input int n, input int budget);
    int c;
    c = 0;
    while (npop < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    if (npop < n) begin
      nvec++;
      nerr++;
      $display("FAIL pops: got %0d want %0d", npop, n);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, 32'(valid), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_done"}, 32'(done), 0);
    chk({nm, "_k"}, 32'(k), 0);
    chk({nm, "_i"}, 32'(i), 0);
    chk({nm, "_p"}, 32'(p), 0);
  endtask

  // Back-pressure driver: ready changes just after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1 ready = bp_en ? ($urandom_range(0, 9) >= 3) : 1'b1;
    end
  end

  // Monitor: compare every consumed tuple against the scoreboard head
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) begin
      mid_stage = 1'b0;
    end else begin
      if (valid && first_cyc < 0) first_cyc = cyc;
      if (mid_stage) chk("valid_hold", 32'(valid), 1);
      if (done) begin
        ndone++;
        done_cyc = cyc;
        chk("done_busy", 32'(busy), 0);
        chk("done_valid", 32'(valid), 0);
      end
      if (valid && ready) begin
        if (q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL extra_tuple: got %0d/%0d/%0d want none", k, i, p);
        end else begin
          e = q.pop_front();
          chk("tuple", 32'({k, i, p}), 32'({e.k, e.i, e.p}));
          if (spot_en)
            for (int j = 0; j < 10; j++)
              if (hidx[j] == npop)
                chk("spot", 32'({k, i, p}), 32'({hk[j], hi[j], hp[j]}));
          mid_stage = !e.last;
          npop++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int n0;
    rst_n = 1'b1;
    start = 1'b0;
    ready = 1'b0;
`ifdef NTT_INV_ORDER_EN
    inv = 1'b0;
`endif
    lp = '0;
    #1 rst_n = 1'b0;
    #2 chk_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int j = 0; j < 10; j++) begin
      lp = 4'(j);
      #1;
      chk("kmax", 32'(lk), 32'(lkx[j]));
      chk("imax", 32'(li), 32'(lix[j]));
    end

    // Run 1: full throughput, latency check
    push_run(1'b0);
    spot_en = 1'b1;
    npop = 0;
    first_cyc = -1;
    pulse_start();
    chk("busy_run", 32'(busy), 1);
    chk("valid_run", 32'(valid), 1);
    wait_done(3000, "run1");
    chk("run1_lat", 32'(done_cyc - first_cyc), 32'(1280 + 9 * G));
    chk("run1_left", 32'(q.size()), 0);
    chk("run1_pops", 32'(npop), 1280);
    @(posedge clk);
    #1;
    chk("hold_kip", 32'({k, i, p}), 32'({7'd0, 7'd127, 4'd9}));
    chk("idle_busy", 32'(busy), 0);

    // Run 2: random back-pressure, start pulses in RUN and DONE
    push_run(1'b0);
    npop = 0;
    n0 = ndone;
    bp_en = 1'b1;
    pulse_start();
    wait_pops(300, 2000);
    pulse_start();
    seen = 1'b0;
    for (int c = 0; c < 4000 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    end
    if (!seen) begin
      nvec++;
      nerr++;
      $display("FAIL run2_done: got none want pulse");
    end
    repeat (5) @(posedge clk);
    #1;
    chk("norestart_valid", 32'(valid), 0);
    chk("norestart_busy", 32'(busy), 0);
    chk("one_done", 32'(ndone - n0), 1);
    chk("run2_left", 32'(q.size()), 0);
    chk("run2_pops", 32'(npop), 1280);
    bp_en = 1'b0;

    // Run 3: asynchronous reset mid-run, then a clean restart
    push_run(1'b0);
    npop = 0;
    pulse_start();
    wait_pops(500, 1000);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_zero("midrst");
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    push_run(1'b0);
    npop = 0;
    first_cyc = -1;
    pulse_start();
    wait_done(3000, "run3");
    chk("run3_lat", 32'(done_cyc - first_cyc), 32'(1280 + 9 * G));
    chk("run3_left", 32'(q.size()), 0);

`ifdef NTT_INV_ORDER_EN
    // Run 4: descending stage order
    spot_en = 1'b0;
    push_run(1'b1);
    npop = 0;
    inv = 1'b1;
    pulse_start();
    inv = 1'b0;
    wait_done(3000, "run_inv");
    chk("inv_left", 32'(q.size()), 0);
    chk("inv_pops", 32'(npop), 1280);
    chk("inv_last", 32'({k, i, p}), 32'({7'd127, 7'd0, 4'd0}));
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
